// File: rtl/gb_ppu_pkg.sv
// Shared PPU definitions used by the background fetcher, pixel FIFO and mixer.
package gb_ppu_pkg;

    // Visible pixels per scanline.
    localparam int unsigned X_MAX = 160;

    typedef logic [1:0] pixel_t;
    typedef pixel_t tile_row_t [7:0];

endpackage

// File: rtl/bgp_shade_map.sv
// Combinational background palette lookup: 2-bit colour index + BGP -> 2-bit shade.
module bgp_shade_map
    import gb_ppu_pkg::*;
(
    input  pixel_t     idx_i,
    input  logic [7:0] bgp_i,
    output pixel_t     shade_o
);

    // Index n selects BGP[2n+1:2n].
    always_comb begin
        shade_o = bgp_i[1:0];
        unique case (idx_i)
            2'd0: shade_o = bgp_i[1:0];
            2'd1: shade_o = bgp_i[3:2];
            2'd2: shade_o = bgp_i[5:4];
            2'd3: shade_o = bgp_i[7:6];
            default: shade_o = bgp_i[1:0];
        endcase
    end

endmodule

// File: rtl/bg_pixel_fifo.sv
// Background pixel FIFO for mode 3: takes one 8-pixel tile row when empty, pops one
// pixel per T-cycle, drops SCX[2:0] leading pixels for fine scroll and tracks X.
// Optional build macro BG_FIFO_PALETTE_MAP_EN maps popped indices through BGP_in.
module bg_pixel_fifo
    import gb_ppu_pkg::pixel_t;
    import gb_ppu_pkg::tile_row_t;
#(
    parameter int unsigned X_MAX = gb_ppu_pkg::X_MAX
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       tclk_in,
    input  logic                       line_start_in,
    input  logic [7:0]                 SCX_in,
    input  logic                       stall_in,
    input  logic                       valid_pixels_in,
    input  tile_row_t                  pixels_in,
    input  logic [7:0]                 BGP_in,
    output logic                       fifo_empty_out,
    output logic                       pixel_valid_out,
    output logic [1:0]                 pixel_out,
    output logic [$clog2(X_MAX)-1:0]   X_out,
    output logic                       line_done_out
);

    localparam int unsigned XW = $clog2(X_MAX);
    localparam logic [XW-1:0] XLast = XW'(X_MAX - 1);

    tile_row_t     storage_q, storage_d;
    logic [3:0]    count_q, count_d;
    logic [2:0]    discard_q, discard_d;
    logic          active_q, active_d;
    logic [XW-1:0] x_q, x_d;
    logic          pix_valid_q, pix_valid_d;
    pixel_t        pix_q, pix_d;
    logic          line_done_q, line_done_d;
    pixel_t        shade;

`ifdef BG_FIFO_PALETTE_MAP_EN
    bgp_shade_map u_shade_map (
        .idx_i   (storage_q[0]),
        .bgp_i   (BGP_in),
        .shade_o (shade)
    );
`else
    logic unused_bgp;
    assign unused_bgp = ^BGP_in;
    assign shade      = storage_q[0];
`endif

    // Next-state: line start beats push/pop; push only into an empty FIFO; pop otherwise.
    always_comb begin
        storage_d   = storage_q;
        count_d     = count_q;
        discard_d   = discard_q;
        active_d    = active_q;
        x_d         = x_q;
        pix_d       = pix_q;
        pix_valid_d = 1'b0;
        line_done_d = 1'b0;
        if (tclk_in) begin
            if (line_start_in) begin
                active_d  = 1'b1;
                count_d   = 4'd0;
                discard_d = SCX_in[2:0];
                x_d       = '0;
            end else if (active_q) begin
                if (count_q == 4'd0) begin
                    if (valid_pixels_in) begin
                        storage_d = pixels_in;
                        count_d   = 4'd8;
                    end
                end else if (!stall_in) begin
                    for (int i = 0; i < 7; i++) begin
                        storage_d[i] = storage_q[i+1];
                    end
                    storage_d[7] = '0;
                    count_d      = count_q - 4'd1;
                    if (discard_q != 3'd0) begin
                        discard_d = discard_q - 3'd1;
                    end else begin
                        pix_d       = shade;
                        pix_valid_d = 1'b1;
                        if (x_q == XLast) begin
                            // Last visible pixel: close the line and block further traffic.
                            line_done_d = 1'b1;
                            active_d    = 1'b0;
                            count_d     = 4'd0;
                            x_d         = '0;
                        end else begin
                            x_d = x_q + 1'b1;
                        end
                    end
                end
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < 8; i++) begin
                storage_q[i] <= '0;
            end
            count_q     <= 4'd0;
            discard_q   <= 3'd0;
            active_q    <= 1'b0;
            x_q         <= '0;
            pix_valid_q <= 1'b0;
            pix_q       <= '0;
            line_done_q <= 1'b0;
        end else begin
            storage_q   <= storage_d;
            count_q     <= count_d;
            discard_q   <= discard_d;
            active_q    <= active_d;
            x_q         <= x_d;
            pix_valid_q <= pix_valid_d;
            pix_q       <= pix_d;
            line_done_q <= line_done_d;
        end
    end

    assign fifo_empty_out  = (count_q == 4'd0);
    assign pixel_valid_out = pix_valid_q;
    assign pixel_out       = pix_q;
    assign X_out           = x_q;
    assign line_done_out   = line_done_q;

endmodule

// File: tb/tb_bg_pixel_fifo.sv
// Scoreboard bench for bg_pixel_fifo: a queue-based line model produces expected pixels,
// a monitor compares them as the DUT emits. Honours BG_FIFO_PALETTE_MAP_EN.
module tb_bg_pixel_fifo;
    import gb_ppu_pkg::*;

    localparam int XLAST = X_MAX - 1;

    logic       clk_in = 1'b0;
    logic       rst_n_in = 1'b0;
    logic       tclk_in = 1'b0;
    logic       line_start_in = 1'b0;
    logic [7:0] SCX_in = '0;
    logic       stall_in = 1'b0;
    logic       valid_pixels_in = 1'b0;
    tile_row_t  pixels_in;
    logic [7:0] BGP_in = '0;
    logic       fifo_empty_out;
    logic       pixel_valid_out;
    logic [1:0] pixel_out;
    logic [$clog2(X_MAX)-1:0] X_out;
    logic       line_done_out;

    bg_pixel_fifo dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .tclk_in         (tclk_in),
        .line_start_in   (line_start_in),
        .SCX_in          (SCX_in),
        .stall_in        (stall_in),
        .valid_pixels_in (valid_pixels_in),
        .pixels_in       (pixels_in),
        .BGP_in          (BGP_in),
        .fifo_empty_out  (fifo_empty_out),
        .pixel_valid_out (pixel_valid_out),
        .pixel_out       (pixel_out),
        .X_out           (X_out),
        .line_done_out   (line_done_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int pix;
        int x_after;
        int done;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   done_exp = 0;
    int   done_seen = 0;

    // Reference line model: pending pixels as a queue, plus scroll discard and X.
    bit   m_active = 0;
    int   m_x = 0;
    int   m_disc = 0;
    int   m_fifo[$];

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int shade_of(input int idx, input logic [7:0] bgp);
`ifdef BG_FIFO_PALETTE_MAP_EN
        return (int'(bgp) >> (2 * idx)) & 3;
`else
        return idx;
`endif
    endfunction

    task automatic rand_row(output tile_row_t r);
        for (int i = 0; i < 8; i++) r[i] = 2'($urandom_range(0, 3));
    endtask

    task automatic model_reset();
        m_active = 0;
        m_x = 0;
        m_disc = 0;
        m_fifo.delete();
    endtask

    // One clk_in cycle: check observable state against the model, drive, advance model.
    task automatic step(input bit tc, input bit ls, input logic [7:0] scx, input bit st,
                        input bit v, input tile_row_t px, input logic [7:0] bgp);
        exp_t e;
        int p;
        @(negedge clk_in);
        check("fifo_empty", int'(fifo_empty_out), int'(m_fifo.size() == 0));
        check("X_out", int'(X_out), m_x);
        tclk_in = tc;
        line_start_in = ls;
        SCX_in = scx;
        stall_in = st;
        valid_pixels_in = v;
        pixels_in = px;
        BGP_in = bgp;
        if (tc) begin
            if (ls) begin
                m_active = 1;
                m_fifo.delete();
                m_disc = int'(scx[2:0]);
                m_x = 0;
            end else if (m_active) begin
                if (m_fifo.size() == 0) begin
                    if (v) for (int i = 0; i < 8; i++) m_fifo.push_back(int'(px[i]));
                end else if (!st) begin
                    p = m_fifo.pop_front();
                    if (m_disc > 0) begin
                        m_disc--;
                    end else begin
                        e.pix = shade_of(p, bgp);
                        e.done = (m_x == XLAST);
                        e.x_after = e.done ? 0 : m_x + 1;
                        exp_q.push_back(e);
                        if (e.done) begin
                            done_exp++;
                            m_active = 0;
                            m_fifo.delete();
                            m_x = 0;
                        end else begin
                            m_x++;
                        end
                    end
                end
            end
        end
    endtask

    // A T-cycle edge followed by an idle clk_in cycle carrying random junk on every input.
    task automatic tick(input bit ls, input logic [7:0] scx, input bit st, input bit v,
                        input tile_row_t px, input logic [7:0] bgp);
        tile_row_t junk;
        step(1'b1, ls, scx, st, v, px, bgp);
        rand_row(junk);
        step(1'b0, 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), junk, 8'($urandom));
    endtask

    // Monitor: every emitted pixel must match the next scoreboard entry, at that very edge.
    always @(posedge clk_in) begin
        exp_t e;
        #1;
        if (pixel_valid_out) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pixel", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("pixel_out", int'(pixel_out), e.pix);
                check("X_after_pop", int'(X_out), e.x_after);
                check("line_done", int'(line_done_out), e.done);
                if (line_done_out) done_seen++;
            end
        end else begin
            if (line_done_out) check("line_done_without_pixel", 1, 0);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("missing_pixel", 0, 1);
            end
        end
    end

    tile_row_t row_a, row_b, row_3, row_z, row_r;
    logic [7:0] bgp_d;
    int n;

    initial begin
        for (int i = 0; i < 8; i++) begin
            row_a[i] = 2'(i % 4);
            row_b[i] = (i < 4) ? 2'(i) : 2'(7 - i);
            row_3[i] = 2'd3;
            row_z[i] = 2'd0;
        end
        pixels_in = row_z;
        bgp_d = 8'h1B;

        // Reset state
        repeat (2) @(negedge clk_in);
        check("rst_fifo_empty", int'(fifo_empty_out), 1);
        check("rst_pixel_valid", int'(pixel_valid_out), 0);
        check("rst_pixel_out", int'(pixel_out), 0);
        check("rst_X", int'(X_out), 0);
        check("rst_line_done", int'(line_done_out), 0);
        rst_n_in = 1'b1;

        // SCX=0: 0,1,2,3,0,1,2,3 back to back
        tick(1, 8'h00, 0, 0, row_z, bgp_d);
        tick(0, 8'h00, 0, 1, row_a, bgp_d);
        repeat (9) tick(0, 8'h00, 0, 0, row_z, bgp_d);

        // SCX=5: five discards, then 2,1,0
        tick(1, 8'h05, 0, 0, row_z, bgp_d);
        tick(0, 8'h00, 0, 1, row_b, bgp_d);
        repeat (9) tick(0, 8'h00, 0, 0, row_z, bgp_d);

        // Push attempts with count=4 are ignored
        tick(1, 8'hF8, 0, 0, row_z, bgp_d);
        tick(0, 8'h00, 0, 1, row_a, bgp_d);
        repeat (4) tick(0, 8'h00, 0, 0, row_z, bgp_d);
        repeat (4) tick(0, 8'h00, 0, 1, row_3, bgp_d);
        repeat (2) tick(0, 8'h00, 0, 0, row_z, bgp_d);

        // Stall for 3 T-cycles mid-row
        tick(1, 8'h00, 0, 0, row_z, bgp_d);
        tick(0, 8'h00, 0, 1, row_b, bgp_d);
        repeat (3) tick(0, 8'h00, 0, 0, row_z, bgp_d);
        repeat (3) tick(0, 8'h00, 1, 0, row_z, bgp_d);
        repeat (6) tick(0, 8'h00, 0, 0, row_z, bgp_d);

        // Full line with continuous pushes and occasional stalls
        tick(1, 8'($urandom), 0, 0, row_z, 8'($urandom));
        n = 0;
        while (m_active && n < 800) begin
            rand_row(row_r);
            tick(0, 8'h00, ($urandom_range(0, 7) == 0), 1, row_r, 8'($urandom));
            n++;
        end
        check("full_line_finished", int'(m_active), 0);
        repeat (3) tick(0, 8'h00, 0, 1, row_3, bgp_d);

        // Random lines, occasional restart mid-line
        for (int l = 0; l < 5; l++) begin
            tick(1, 8'($urandom), 0, 0, row_z, 8'($urandom));
            n = 0;
            while (m_active && n < 1500) begin
                rand_row(row_r);
                tick(($urandom_range(0, 299) == 0), 8'($urandom),
                     ($urandom_range(0, 3) == 0), 1'($urandom), row_r, 8'($urandom));
                n++;
            end
            check("random_line_finished", int'(m_active), 0);
        end

        // Reset mid-row drops everything
        tick(1, 8'h00, 0, 0, row_z, bgp_d);
        tick(0, 8'h00, 0, 1, row_a, bgp_d);
        repeat (3) tick(0, 8'h00, 0, 0, row_z, bgp_d);
        @(negedge clk_in);
        rst_n_in = 1'b0;
        #1;
        check("midrst_fifo_empty", int'(fifo_empty_out), 1);
        check("midrst_pixel_valid", int'(pixel_valid_out), 0);
        check("midrst_pixel_out", int'(pixel_out), 0);
        check("midrst_X", int'(X_out), 0);
        check("midrst_line_done", int'(line_done_out), 0);
        model_reset();
        exp_q.delete();
        @(negedge clk_in);
        rst_n_in = 1'b1;
        // Inactive after reset: pushes ignored until a new line start
        repeat (3) tick(0, 8'h00, 0, 1, row_a, bgp_d);
        tick(1, 8'h02, 0, 0, row_z, bgp_d);
        tick(0, 8'h00, 0, 1, row_a, bgp_d);
        repeat (9) tick(0, 8'h00, 0, 0, row_z, bgp_d);

        repeat (3) @(negedge clk_in);
        check("scoreboard_drained", exp_q.size(), 0);
        check("line_done_count", done_seen, done_exp);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
